// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full_adder reused LSB-first with the carry held in a flip-flop.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_sum_sh, r_sum, w_sum_nxt;
  logic [CW-1:0] r_count;
  logic r_carry_q, r_carry_out, r_result_valid, w_fa_s, w_fa_c, w_accept, w_last;
  full_adder u_fa (
    .a(r_a_sh[0]),
    .b(r_b_sh[0]),
    .carry_in(r_carry_q),
    .sum(w_fa_s),
    .carry_out(w_fa_c)
  );
  always_comb begin
    w_accept = start_valid && r_state == IDLE;
    w_last = r_state == RUN && r_count == CW'(WIDTH - 1);
    w_sum_nxt = (r_sum_sh >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));
    w_state_nxt = w_accept ? RUN : w_last ? DONE : (r_state == DONE && result_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // sum register is written only on the final bit so it holds after the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_sum_sh <= '0;
      r_carry_q <= 1'b0;
      r_count <= '0;
      r_sum <= '0;
      r_carry_out <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_sh <= a;
        r_b_sh <= b;
        r_carry_q <= carry_in;
        r_count <= '0;
      end else if (r_state == RUN) begin
        r_a_sh <= r_a_sh >> 1;
        r_b_sh <= r_b_sh >> 1;
        r_sum_sh <= w_sum_nxt;
        r_carry_q <= w_fa_c;
        r_count <= r_count + 1'b1;
      end
      if (w_last) begin
        r_sum <= w_sum_nxt;
        r_carry_out <= w_fa_c;
      end
      r_result_valid <= w_state_nxt == DONE;
    end
  end
  assign start_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign result_valid = r_result_valid;
  assign sum = r_sum;
  assign carry_out = r_carry_out;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic sv8 = 1'b0, cin8 = 1'b0, rr8 = 1'b1, sr8, rv8, co8, bz8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic sv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, rr1 = 1'b1, sr1, rv1, co1, bz1;
  logic [0:0] s1;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8), .a(a8), .b(b8),
    .carry_in(cin8), .result_valid(rv8), .result_ready(rr8), .sum(s8), .carry_out(co8), .busy(bz8)
  );
  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1), .a(a1), .b(b1),
    .carry_in(cin1), .result_valid(rv1), .result_ready(rr1), .sum(s1), .carry_out(co1), .busy(bz1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input int hold,
                     input bit wiggle, input bit pulse);
    logic [8:0] e;
    int lat;
    chk("rdy8", sr8, 1);
    sv8 = 1'b1; a8 = a; b8 = b; cin8 = cin; rr8 = (hold == 0);
    @(posedge clk); #1;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
    sv8 = 1'b0;
    chk("run_rdy8", sr8, 0);
    chk("run_busy8", bz8, 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (wiggle) begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~cin8; end
      if (pulse) begin sv8 = 1'b1; a8 = 8'hAA; end
      @(posedge clk); #1;
      if (rv8) begin lat = k; break; end
    end
    sv8 = 1'b0;
    if (lat == 0) begin chk("timeout8", 0, 1); return; end
    chk("lat8", lat, 8);
    e = q8.pop_front();
    chk("sum8", s8, e[7:0]);
    chk("cout8", co8, e[8]);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_rv8", rv8, 1);
      chk("hold_sum8", {co8, s8}, e);
      chk("hold_rdy8", sr8, 0);
    end
    rr8 = 1'b1;
    @(posedge clk); #1;
    chk("rv_drop8", rv8, 0);
    chk("idle_rdy8", sr8, 1);
    chk("after_sum8", {co8, s8}, e);
  endtask
  task automatic op1(input logic a, input logic b, input logic cin);
    logic [1:0] e;
    int lat;
    sv1 = 1'b1; a1 = a; b1 = b; cin1 = cin;
    @(posedge clk); #1;
    q1.push_back({1'b0, a} + {1'b0, b} + 2'(cin));
    sv1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~cin;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (rv1) begin lat = k; break; end
    end
    if (lat == 0) begin chk("timeout1", 0, 1); return; end
    chk("lat1", lat, 1);
    e = q1.pop_front();
    chk("res1", {co1, s1}, e);
    @(posedge clk); #1;
    chk("rv_drop1", rv1, 0);
  endtask
  initial begin
    #12;
    chk("rst_rdy8", sr8, 1);
    chk("rst_rv8", rv8, 0);
    chk("rst_busy8", bz8, 0);
    chk("rst_out8", {co8, s8}, 0);
    chk("rst_rdy1", sr1, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    op8(8'h5A, 8'h3C, 1'b0, 0, 0, 0);
    op8(8'hFF, 8'h01, 1'b0, 0, 0, 0);
    op8(8'hFF, 8'hFF, 1'b1, 0, 0, 0);
    op8(8'h12, 8'h34, 1'b0, 5, 0, 1);
    op8(8'hC3, 8'h7E, 1'b1, 0, 1, 0);
    op8(8'h9D, 8'h64, 1'b0, 2, 1, 0);
    sv8 = 1'b1; a8 = 8'h77; b8 = 8'h66; cin8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("mid_rst_rdy", sr8, 1);
    chk("mid_rst_busy", bz8, 0);
    chk("mid_rst_rv", rv8, 0);
    chk("mid_rst_out", {co8, s8}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rv", rv8, 0);
    op8(8'h80, 8'h80, 1'b0, 0, 0, 0);
    op1(1'b1, 1'b1, 1'b1);
    op1(1'b0, 1'b0, 1'b0);
    op1(1'b1, 1'b0, 1'b0);
    op1(1'b0, 1'b1, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
